// File: rtl/neosd_pkg.sv
// Shared constants for the neosd Wishbone data buffer: register map, STATUS layout, direction codes.
package neosd_pkg;

  localparam logic DATBUF_ADDR_DATA   = 1'b0;
  localparam logic DATBUF_ADDR_STATUS = 1'b1;

  localparam logic DIR_RX = 1'b0;
  localparam logic DIR_TX = 1'b1;

  localparam int unsigned STATUS_W       = 32;
  localparam int unsigned ST_LEVEL_W     = 16;
  localparam int unsigned ST_FLUSH_BIT   = 0;
  localparam int unsigned ST_EMPTY_BIT   = 16;
  localparam int unsigned ST_FULL_BIT    = 17;
  localparam int unsigned ST_THRESH_BIT  = 18;
  localparam int unsigned ST_DIR_BIT     = 19;
  localparam int unsigned ST_ERR_BIT     = 20;
  localparam int unsigned ST_IRQ_EN_BIT  = 24;

endpackage

// File: rtl/neosd_fifo.sv
// Generic synchronous FIFO with flush; full/empty derive from the registered level only.
module neosd_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [DATA_W-1:0]          head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [LVL_W-1:0]  level_q, level_d;

  // Next-state for storage, pointers and level; flush overrides push/pop.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = wptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push_i && !pop_i) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop_i && !push_i) begin
        level_d = level_q - LVL_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/neosd_wb_datbuf.sv
// Wishbone data buffer between the bus and the neosd DAT FSM; direction follows dir_i.
module neosd_wb_datbuf
  import neosd_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned THRESH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic                    wb_adr_i,
  input  logic [DATA_W/8-1:0]     wb_sel_i,
  input  logic [DATA_W-1:0]       wb_dat_i,
  output logic [DATA_W-1:0]       wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_stall_o,
  input  logic                    dir_i,
  input  logic                    rx_valid_i,
  input  logic [DATA_W-1:0]       rx_data_i,
  output logic                    rx_ready_o,
  output logic                    tx_valid_o,
  output logic [DATA_W-1:0]       tx_data_o,
  input  logic                    tx_ready_i,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    irq_o
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              fifo_full, fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [DATA_W-1:0] fifo_head;

  logic              is_data_c, sel_ok_c, accept_c, stall_c;
  logic              bus_push_c, bus_pop_c, fsm_push_c, fsm_pop_c;
  logic              push_c, pop_c, flush_c, thresh_hit_c;
  logic [DATA_W-1:0] push_data_c;
  logic [STATUS_W-1:0] status_c;

  logic              ack_q, ack_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;
  logic              irq_en_q, irq_en_d;
  logic              dir_q, dir_d;

  neosd_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_c),
    .data_i  (push_data_c),
    .pop_i   (pop_c),
    .flush_i (flush_c),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level),
    .head_o  (fifo_head)
  );

  // Handshake, direction muxing, FIFO control and STATUS image.
  always_comb begin
    is_data_c   = (wb_adr_i == DATBUF_ADDR_DATA);
    sel_ok_c    = (wb_sel_i == '1);
    stall_c     = wb_stb_i && is_data_c &&
                  (( wb_we_i && (dir_i == DIR_TX) && fifo_full) ||
                   (!wb_we_i && (dir_i == DIR_RX) && fifo_empty));
    accept_c    = wb_stb_i && !stall_c;
    bus_push_c  = accept_c && is_data_c &&  wb_we_i && (dir_i == DIR_TX) && sel_ok_c;
    bus_pop_c   = accept_c && is_data_c && !wb_we_i && (dir_i == DIR_RX);
    fsm_push_c  = (dir_i == DIR_RX) && rx_valid_i && !fifo_full;
    fsm_pop_c   = (dir_i == DIR_TX) && tx_ready_i && !fifo_empty;
    push_c      = bus_push_c || fsm_push_c;
    pop_c       = bus_pop_c || fsm_pop_c;
    push_data_c = (dir_i == DIR_TX) ? wb_dat_i : rx_data_i;
    flush_c     = (dir_i != dir_q) ||
                  (accept_c && !is_data_c && wb_we_i && wb_dat_i[ST_FLUSH_BIT]);
    if (dir_i == DIR_RX) begin
      thresh_hit_c = (fifo_level >= LVL_W'(THRESH));
    end else begin
      thresh_hit_c = ((LVL_W'(DEPTH) - fifo_level) >= LVL_W'(THRESH));
    end
    status_c                   = '0;
    status_c[ST_LEVEL_W-1:0]   = ST_LEVEL_W'(fifo_level);
    status_c[ST_EMPTY_BIT]     = fifo_empty;
    status_c[ST_FULL_BIT]      = fifo_full;
    status_c[ST_THRESH_BIT]    = thresh_hit_c;
    status_c[ST_DIR_BIT]       = dir_i;
    status_c[ST_ERR_BIT]       = err_q;
    status_c[ST_IRQ_EN_BIT]    = irq_en_q;
  end

  // Next-state for ack, read data, IRQ, sticky error, irq enable and direction copy.
  always_comb begin
    ack_d    = accept_c;
    dat_d    = '0;
    irq_d    = irq_en_q && thresh_hit_c;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    dir_d    = dir_i;
    if (accept_c && !wb_we_i) begin
      if (!is_data_c) begin
        dat_d = DATA_W'(status_c);
      end else if (dir_i == DIR_RX) begin
        dat_d = fifo_head;
      end
    end
    if (accept_c && is_data_c) begin
      if (wb_we_i && ((dir_i == DIR_RX) || !sel_ok_c)) begin
        err_d = 1'b1;
      end else if (!wb_we_i && (dir_i == DIR_TX)) begin
        err_d = 1'b1;
      end
    end
    if (accept_c && !is_data_c && wb_we_i) begin
      irq_en_d = wb_dat_i[ST_IRQ_EN_BIT];
      if (wb_dat_i[ST_ERR_BIT]) begin
        err_d = 1'b0;
      end
    end
  end

  // Output and control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      dir_q    <= DIR_RX;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      dir_q    <= dir_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign wb_stall_o = stall_c;
  assign irq_o      = irq_q;
  assign rx_ready_o = (dir_i == DIR_RX) && !fifo_full;
  assign tx_valid_o = (dir_i == DIR_TX) && !fifo_empty;
  assign tx_data_o  = fifo_head;
  assign level_o    = fifo_level;

endmodule

// File: tb/tb_neosd_wb_datbuf.sv
// Self-checking bench for neosd_wb_datbuf with a data-ordering scoreboard.
module tb_neosd_wb_datbuf;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned THRESH = 8;
  localparam int unsigned LVL_W  = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              wb_stb_i, wb_we_i, wb_adr_i;
  logic [3:0]        wb_sel_i;
  logic [DATA_W-1:0] wb_dat_i, wb_dat_o;
  logic              wb_ack_o, wb_stall_o;
  logic              dir_i, rx_valid_i, rx_ready_o, tx_valid_o, tx_ready_i, irq_o;
  logic [DATA_W-1:0] rx_data_i, tx_data_o;
  logic [LVL_W-1:0]  level_o;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] sb[$];

  neosd_wb_datbuf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_stall_o(wb_stall_o),
    .dir_i(dir_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
    .level_o(level_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One Wishbone access; waits out stalls (bounded) and checks the ack.
  task automatic bus_xfer(input logic we, input logic adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rd);
    int n = 0;
    wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    #1;
    while (wb_stall_o === 1'b1 && n < 200) begin
      tick(); #1; n++;
    end
    rd = '0;
    if (n >= 200) begin
      tests_run++; tests_failed++;
      $display("FAIL bus_stall_timeout: still stalled after %0d cycles", n);
      wb_stb_i = 1'b0;
      return;
    end
    tick();
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tests_run++;
    if (wb_ack_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL bus_ack: got %b expected 1", wb_ack_o);
    end
    rd = wb_dat_o;
  endtask

  task automatic fsm_push(input logic [31:0] d);
    rx_valid_i = 1'b1; rx_data_i = d;
    tick();
    rx_valid_i = 1'b0;
    sb.push_back(d);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; dir_i = 1'b0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_sel_i = 4'hF;
    wb_dat_i = '0; rx_valid_i = 0; rx_data_i = '0; tx_ready_i = 0;
    repeat (3) tick();
    tests_run++;
    if ({wb_ack_o, irq_o, tx_valid_o, rx_ready_o} !== 4'b0001 || wb_dat_o !== '0 || level_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ack/irq/txv/rxr=%b dat=%h level=%0d expected 0001/0/0",
               {wb_ack_o, irq_o, tx_valid_o, rx_ready_o}, wb_dat_o, level_o);
    end
    rst_i = 1'b0;
    tick();
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b1;
    #1;
    tests_run++;
    if (wb_ack_o !== 1'b0 || wb_stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL status_pre_ack: ack=%b stall=%b expected 0 0", wb_ack_o, wb_stall_o);
    end
    tick();
    wb_stb_i = 1'b0;
    tests_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h0001_0000) begin
      tests_failed++;
      $display("FAIL status_reset: ack=%b dat=%h expected 1 00010000", wb_ack_o, wb_dat_o);
    end
    tick();
    tests_run++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== '0) begin
      tests_failed++;
      $display("FAIL ack_single: ack=%b dat=%h expected 0 00000000", wb_ack_o, wb_dat_o);
    end
  endtask

  task automatic test_tx_fill();
    logic [31:0] rd;
    int n;
    dir_i = 1'b1; tick(); tick();
    sb.delete();
    for (int i = 0; i < 16; i++) begin
      bus_xfer(1'b1, 1'b0, 32'h100 + 32'(i), 4'hF, rd);
      sb.push_back(32'h100 + 32'(i));
    end
    bus_xfer(1'b0, 1'b1, '0, 4'hF, rd);
    tests_run++;
    if (level_o !== 5'd16 || rd !== 32'h000A_0010) begin
      tests_failed++;
      $display("FAIL tx_full_status: level=%0d status=%h expected 16 000a0010", level_o, rd);
    end
    wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 1'b0; wb_dat_i = 32'h110; wb_sel_i = 4'hF;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (wb_stall_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL tx_full_stall: stall=%b expected 1", wb_stall_o);
      end
      tick();
    end
    tests_run++;
    if (tx_valid_o !== 1'b1 || tx_data_o !== sb[0]) begin
      tests_failed++;
      $display("FAIL tx_head_at_full: valid=%b data=%h expected 1 %h", tx_valid_o, tx_data_o, sb[0]);
    end
    void'(sb.pop_front());
    tx_ready_i = 1'b1;
    tick();
    tx_ready_i = 1'b0;
    #1;
    tests_run++;
    if (wb_stall_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_stall_release: stall=%b expected 0", wb_stall_o);
    end
    sb.push_back(32'h110);
    tick();
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tests_run++;
    if (wb_ack_o !== 1'b1 || level_o !== 5'd16) begin
      tests_failed++;
      $display("FAIL tx_17th_write: ack=%b level=%0d expected 1 16", wb_ack_o, level_o);
    end
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      tx_ready_i = 1'b1;
      #1;
      tests_run++;
      if (tx_valid_o !== 1'b1 || tx_data_o !== sb[0]) begin
        tests_failed++;
        $display("FAIL tx_order: valid=%b data=%h expected 1 %h", tx_valid_o, tx_data_o, sb[0]);
      end
      void'(sb.pop_front());
      tick();
      n++;
    end
    tx_ready_i = 1'b0;
    #1;
    tests_run++;
    if (level_o !== '0 || tx_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL tx_drained: level=%0d valid=%b expected 0 0", level_o, tx_valid_o);
    end
  endtask

  task automatic test_rx_irq();
    logic [31:0] rd;
    dir_i = 1'b0; tick(); tick();
    sb.delete();
    bus_xfer(1'b1, 1'b1, 32'h0100_0000, 4'hF, rd);
    for (int i = 0; i < 8; i++) fsm_push(32'hA000 + 32'(i));
    tests_run++;
    if (level_o !== 5'd8 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_not_early: level=%0d irq=%b expected 8 0", level_o, irq_o);
    end
    tick();
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_rise: irq=%b expected 1", irq_o);
    end
    bus_xfer(1'b0, 1'b0, '0, 4'hF, rd);
    tests_run++;
    if (rd !== sb[0]) begin
      tests_failed++;
      $display("FAIL rx_first_read: got %h expected %h", rd, sb[0]);
    end
    void'(sb.pop_front());
    tick();
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_drop: irq=%b expected 0", irq_o);
    end
    for (int i = 0; i < 7; i++) begin
      bus_xfer(1'b0, 1'b0, '0, 4'hF, rd);
      tests_run++;
      if (rd !== sb[0]) begin
        tests_failed++;
        $display("FAIL rx_order: got %h expected %h", rd, sb[0]);
      end
      void'(sb.pop_front());
    end
    tests_run++;
    if (level_o !== '0) begin
      tests_failed++;
      $display("FAIL rx_drained: level=%0d expected 0", level_o);
    end
    bus_xfer(1'b1, 1'b1, 32'h0, 4'hF, rd);
  endtask

  task automatic test_empty_stall();
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_sel_i = 4'hF;
    #1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (wb_stall_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL empty_stall: stall=%b expected 1", wb_stall_o);
      end
      tick();
    end
    fsm_push(32'hDEAD_BEEF);
    tests_run++;
    if (wb_stall_o !== 1'b0 || wb_ack_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_release: stall=%b ack=%b expected 0 0", wb_stall_o, wb_ack_o);
    end
    tick();
    wb_stb_i = 1'b0;
    tests_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== sb[0]) begin
      tests_failed++;
      $display("FAIL empty_read_data: ack=%b dat=%h expected 1 %h", wb_ack_o, wb_dat_o, sb[0]);
    end
    void'(sb.pop_front());
  endtask

  task automatic test_simul_and_flush();
    for (int i = 0; i < 5; i++) fsm_push(32'hB0 + 32'(i));
    rx_valid_i = 1'b1; rx_data_i = 32'hC0;
    wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_sel_i = 4'hF;
    tick();
    rx_valid_i = 1'b0; wb_stb_i = 1'b0;
    sb.push_back(32'hC0);
    tests_run++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== sb[0] || level_o !== 5'd5) begin
      tests_failed++;
      $display("FAIL simul_push_pop: ack=%b dat=%h level=%0d expected 1 %h 5",
               wb_ack_o, wb_dat_o, level_o, sb[0]);
    end
    void'(sb.pop_front());
    rx_valid_i = 1'b1; rx_data_i = 32'hD0;
    wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 1'b1; wb_dat_i = 32'h1;
    tick();
    rx_valid_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tests_run++;
    if (wb_ack_o !== 1'b1 || level_o !== '0) begin
      tests_failed++;
      $display("FAIL flush_vs_push: ack=%b level=%0d expected 1 0", wb_ack_o, level_o);
    end
    sb.delete();
  endtask

  task automatic test_err();
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, 32'h1234, 4'hF, rd);
    bus_xfer(1'b0, 1'b1, '0, 4'hF, rd);
    tests_run++;
    if (rd !== 32'h0011_0000) begin
      tests_failed++;
      $display("FAIL err_wrong_dir_write: status=%h expected 00110000", rd);
    end
    bus_xfer(1'b1, 1'b1, 32'h0010_0000, 4'hF, rd);
    bus_xfer(1'b0, 1'b1, '0, 4'hF, rd);
    tests_run++;
    if (rd !== 32'h0001_0000) begin
      tests_failed++;
      $display("FAIL err_clear_rx: status=%h expected 00010000", rd);
    end
    dir_i = 1'b1; tick(); tick();
    bus_xfer(1'b1, 1'b0, 32'h55, 4'b0011, rd);
    bus_xfer(1'b0, 1'b1, '0, 4'hF, rd);
    tests_run++;
    if (rd !== 32'h001D_0000) begin
      tests_failed++;
      $display("FAIL err_partial_sel: status=%h expected 001d0000", rd);
    end
    bus_xfer(1'b0, 1'b0, '0, 4'hF, rd);
    tests_run++;
    if (rd !== '0) begin
      tests_failed++;
      $display("FAIL wrong_dir_read: got %h expected 00000000", rd);
    end
    bus_xfer(1'b1, 1'b1, 32'h0010_0000, 4'hF, rd);
    bus_xfer(1'b0, 1'b1, '0, 4'hF, rd);
    tests_run++;
    if (rd !== 32'h000D_0000) begin
      tests_failed++;
      $display("FAIL err_clear_tx: status=%h expected 000d0000", rd);
    end
    dir_i = 1'b0; tick(); tick();
  endtask

  task automatic test_dir_toggle();
    for (int i = 0; i < 3; i++) fsm_push(32'hE0 + 32'(i));
    tests_run++;
    if (level_o !== 5'd3) begin
      tests_failed++;
      $display("FAIL toggle_prefill: level=%0d expected 3", level_o);
    end
    dir_i = 1'b1;
    tick();
    tests_run++;
    if (level_o !== '0 || tx_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL dir_toggle_flush: level=%0d txv=%b expected 0 0", level_o, tx_valid_o);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_xfer(1'b1, 1'b0, 32'hF0, 4'hF, rd);
    bus_xfer(1'b1, 1'b0, 32'hF1, 4'hF, rd);
    wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 1'b0; wb_dat_i = 32'hF2;
    tick();
    wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rst_i = 1'b1;
    #1;
    tests_run++;
    if (wb_ack_o !== 1'b0 || level_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: ack=%b level=%0d expected 0 0", wb_ack_o, level_o);
    end
    tick();
    rst_i = 1'b0; dir_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_tx_fill();
    test_rx_irq();
    test_empty_stall();
    test_simul_and_flush();
    test_err();
    test_dir_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
